cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Multi-cycle sequencer for the rv32im core. It owns the program counter's write-enable, synchronous reset and next-PC select, and steps each instruction through fetch, decode, execute/memory and writeback. It sits between the decoder/ALU/mul-div unit and the PC, instruction memory, data memory and register file, and issues one-cycle strobes to each.

## Interface
- BOOT_CYCLES, 4: number of cycles the PC is held in reset after `reset` deasserts; minimum 1, and 0 is treated as 1.
- INSTRET_W, 32: width of the retired-instruction counter.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_ready  in  1  instruction word valid. Sampled only in FETCH.
- is_load, is_store, is_branch, br_taken, is_jal, is_jalr, is_muldiv, illegal  in  1 each  decoder flags. Held stable by the decoder from DECODE through WB.
- muldiv_done  in  1  mul/div result valid. Sampled only in EXEC.
- dmem_ready  in  1  data access complete. Sampled only in MEM.
- pc_we  out  1  PC write enable.
- pc_rst  out  1  PC synchronous reset, active-high. Effective only together with pc_we.
- pc_sel  out  2  next-PC select: 0 = pc+4, 1 = branch/jal target, 2 = jalr target, 3 = unused (never driven).
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register load.
- dmem_req, dmem_we  out  1 each  data memory request and write qualifier.
- muldiv_start  out  1  one-cycle mul/div start pulse.
- rf_we  out  1  register file write.
- halted  out  1  controller is in HALT.
- state  out  3  current state, for debug.
- instret  out  INSTRET_W  count of retired instructions.

## Operation
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable; if entered, go to HALT.
- Registers: state, boot_cnt, instret. All other outputs are combinational decodes of state and the inputs.
- Reset (reset=0): state=BOOT, boot_cnt=0, instret=0. Outputs while in reset: pc_we=1, pc_rst=1; every other strobe 0; halted=0; pc_sel=0.
- BOOT: pc_we=1, pc_rst=1, boot_cnt increments each cycle. When boot_cnt = max(BOOT_CYCLES,1)-1, go to FETCH.
- FETCH: imem_req=1. When imem_ready=1: ir_we=1 in the same cycle, go to DECODE. Otherwise stay in FETCH, with no timeout.
- DECODE (exactly one cycle), priority order:
  - illegal: go to HALT.
  - is_muldiv: muldiv_start=1, go to EXEC.
  - is_load or is_store: go to MEM.
  - otherwise: go to WB.
- EXEC: wait for muldiv_done=1, then go to WB.
- MEM: dmem_req=1, dmem_we=is_store. When dmem_ready=1, go to WB. Both strobes are held until ready.
- WB (one cycle):
  - pc_we=1.
  - rf_we = !is_store & !is_branch.
  - pc_sel = 1 if is_jal or (is_branch & br_taken); 2 if is_jalr; else 0.
  - instret += 1, wrapping from all-ones to 0.
  - Go to FETCH.
- HALT: halted=1, all strobes 0, pc_we=0. Stays in HALT until reset.
- pc_rst=1 only in BOOT. pc_we=1 only in BOOT and WB.

## Timing
- Cycles per instruction, counting FETCH entry to the next FETCH entry, with zero-wait memories:
  - ALU, branch, jal, jalr: 3 (FETCH, DECODE, WB).
  - load/store: 4.
  - mul/div: 3 + N, where N is the number of EXEC cycles up to and including the muldiv_done cycle.
- PC update: the new PC is visible the cycle after WB, in FETCH.
- Handshakes are level ready, single-cycle acceptance. A ready asserted in any state other than its sampling state is ignored and is never remembered.
- muldiv_done asserted in the DECODE/start cycle is ignored. The earliest accepted completion is the first EXEC cycle.
- Reset asserted mid-instruction: state goes to BOOT asynchronously, strobes drop immediately, and instret clears. No partial writeback.
- After reset deassertion: first imem_req at cycle BOOT_CYCLES (cycle 0 = first rising edge with reset=1).

## Test plan
- Boot: BOOT_CYCLES=4, release reset. Expect pc_we=pc_rst=1 for 4 cycles, then imem_req=1 on cycle 4, pc_rst=0 from then on.
- ALU op with imem_ready tied high. Expect states 1,2,5,1 repeating; pc_we and rf_we high only in WB, pc_sel=0; instret=10 after 10 instructions (30 cycles).
- Taken branch (is_branch=1, br_taken=1), then jalr, then store with dmem_ready delayed 3 cycles:
  - branch: pc_sel=1 and rf_we=0 in WB.
  - jalr: pc_sel=2 and rf_we=1 in WB.
  - store: dmem_req=dmem_we=1 for 4 cycles, rf_we=0 in WB.
- mul/div with muldiv_done pulsed in the DECODE cycle and again 5 cycles into EXEC. Expect the first pulse ignored, one muldiv_start pulse, WB the cycle after the second pulse.
- illegal=1 in DECODE. Expect HALT with halted=1 and pc_we=0 indefinitely, imem_ready toggling ignored. Assert reset: BOOT, instret=0.
- Reset mid-MEM (dmem_req=1). Expect dmem_req to drop combinationally with reset, state=0, and no WB strobe. With INSTRET_W=4, 16 retirements wrap instret to 0.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl - multi-cycle instruction sequencer for the rv32im core.
//
// Steps each instruction through FETCH, DECODE, EXEC/MEM and WB and issues
// one-cycle strobes to the PC, instruction memory, data memory, mul/div unit
// and register file. Owns the PC write enable, PC synchronous reset and
// next-PC select, and counts retired instructions.
//
// Parameters
//   BOOT_CYCLES  cycles the PC is held in reset after reset release (0 -> 1)
//   INSTRET_W    width of the retired-instruction counter
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   imem_ready    instruction word valid (looked at in FETCH only)
//   is_load .. illegal
//                 decoder flags, stable from DECODE through WB
//   muldiv_done   mul/div result valid (looked at in EXEC only)
//   dmem_ready    data access complete (looked at in MEM only)
//   pc_we         PC write enable
//   pc_rst        PC synchronous reset, qualified by pc_we
//   pc_sel        next PC: 0 pc+4, 1 branch/jal target, 2 jalr target
//   imem_req      instruction fetch request
//   ir_we         instruction register load
//   dmem_req      data memory request
//   dmem_we       data memory write qualifier
//   muldiv_start  one-cycle mul/div start pulse
//   rf_we         register file write
//   halted        controller is in HALT
//   state         current state, debug
//   instret       retired-instruction count, wraps
//
// state  | meaning
// -------+------------------------------------------------------------
// BOOT   | PC held in reset for BOOT_CYCLES cycles
// FETCH  | request instruction, load IR on imem_ready
// DECODE | one cycle, choose path from decoder flags (illegal first)
// EXEC   | wait for muldiv_done
// MEM    | data access, strobes held until dmem_ready
// WB     | one cycle: PC update, register write, instret + 1
// HALT   | illegal instruction seen, idle until reset
// (7)    | unreachable, recovers into HALT

module cpu_seq_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_ready,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_branch,
    input  logic                 br_taken,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic                 is_muldiv,
    input  logic                 illegal,
    input  logic                 muldiv_done,
    input  logic                 dmem_ready,
    output logic                 pc_we,
    output logic                 pc_rst,
    output logic [1:0]           pc_sel,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 muldiv_start,
    output logic                 rf_we,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam int BOOT_EFF = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int BCW      = (BOOT_EFF > 1) ? $clog2(BOOT_EFF) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_EFF - 1);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t         cur_state;
    state_t         nxt_state;
    logic [BCW-1:0] boot_cnt;
    logic           boot_done;

    assign state     = cur_state;
    assign boot_done = (boot_cnt == BOOT_LAST);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_BOOT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // boot counter; cleared on the exit cycle so it never runs past BOOT_LAST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boot_cnt <= '0;
        end else if (cur_state == S_BOOT) begin
            if (boot_done) begin
                boot_cnt <= '0;
            end else begin
                boot_cnt <= boot_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (cur_state == S_WB) begin
            instret <= instret + 1'b1;
        end
    end

    // next-state logic
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_BOOT:   if (boot_done) nxt_state = S_FETCH;
            S_FETCH:  if (imem_ready) nxt_state = S_DECODE;
            S_DECODE: begin
                if (illegal) begin
                    nxt_state = S_HALT;
                end else if (is_muldiv) begin
                    nxt_state = S_EXEC;
                end else if (is_load || is_store) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_EXEC:   if (muldiv_done) nxt_state = S_WB;
            S_MEM:    if (dmem_ready) nxt_state = S_WB;
            S_WB:     nxt_state = S_FETCH;
            S_HALT:   nxt_state = S_HALT;
            default:  nxt_state = S_HALT;
        endcase
    end

    // output decode
    always_comb begin
        pc_we        = 1'b0;
        pc_rst       = 1'b0;
        pc_sel       = 2'd0;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        muldiv_start = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        case (cur_state)
            S_BOOT: begin
                pc_we  = 1'b1;
                pc_rst = 1'b1;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_DECODE: begin
                muldiv_start = !illegal && is_muldiv;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = !is_store && !is_branch;
                if (is_jal || (is_branch && br_taken)) begin
                    pc_sel = 2'd1;
                end else if (is_jalr) begin
                    pc_sel = 2'd2;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
